mac_acc: RTL
============

MAC_ACC -- requirements
Module: mac_acc

Interface
REQ-001 SHALL have parameter IW, default 18: width of the signed product input, matching the upstream multiplier output width.
REQ-002 SHALL have parameter AW, default 32: signed accumulator width, with AW > IW.
REQ-003 SHALL have parameter QW, default 8: width of the signed requantized output.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-006 clr  input  1  synchronous abort of the current frame.
REQ-007 in_valid  input  1  in_data/in_last qualify this cycle.
REQ-008 in_ready  output  1  block accepts a beat this cycle.
REQ-009 in_data  input  IW  signed product term.
REQ-010 in_last  input  1  final term of the frame.
REQ-011 bias  input  AW  signed bias, sampled with the first beat of a frame.
REQ-012 shift  input  5  requant right-shift amount, 0..AW-1, held static during a frame.
REQ-013 out_valid  output  1  result held on the out_* ports.
REQ-014 out_ready  input  1  downstream accepts the result.
REQ-015 out_sum  output  AW  signed accumulated sum.
REQ-016 out_q  output  QW  signed rounded, shifted and saturated sum.
REQ-017 out_cnt  output  16  number of terms accepted in the frame.
REQ-018 out_ovf  output  1  accumulator saturated at least once in the frame.

Function
REQ-019 SHALL implement three states:
- IDLE: no frame in progress.
- ACC: frame in progress.
- OUT: result pending.
REQ-020 SHALL drive in_ready = 1 in IDLE and ACC, and in_ready = 0 in OUT.
REQ-021 SHALL treat a beat as accepted when in_valid && in_ready is true at a rising edge.
REQ-022 On a beat accepted in IDLE, SHALL compute acc = sat(bias + sext(in_data)), cnt = 1, and set ovf from that add.
REQ-023 On a beat accepted in ACC, SHALL compute acc = sat(acc + sext(in_data)), cnt = cnt + 1, and OR the new overflow into ovf.
REQ-024 SHALL evaluate every addition at AW+1 bits; a result outside the AW signed range SHALL clamp to +(2^(AW-1)-1) or -2^(AW-1) and SHALL set ovf.
REQ-025 SHALL saturate cnt at 16'hFFFF with no wrap.
REQ-026 An accepted beat with in_last = 0 SHALL move the state to ACC; an accepted beat with in_last = 1 SHALL move the state to OUT from either IDLE or ACC.
REQ-027 out_valid SHALL be 1 exactly while in OUT; it SHALL first rise in the cycle after the last beat is accepted, for a latency of 1 cycle.
REQ-028 out_sum, out_q, out_cnt and out_ovf SHALL be registered and SHALL stay stable while out_valid = 1 and out_ready = 0.
REQ-029 out_valid && out_ready SHALL return the state to IDLE; the next frame's first beat SHALL be accepted no earlier than the following cycle.
REQ-030 SHALL compute out_q = satQW((acc + r) >>> shift), with r = 0 when shift = 0 and r = 2^(shift-1) otherwise.
- Rounding is half-up.
- The shift is arithmetic.
- The intermediate is AW+1 bits.
REQ-031 clr = 1 SHALL force IDLE, zero acc, cnt and ovf, and drop any pending result, including one in OUT.
REQ-032 clr SHALL take priority over a beat accepted in the same cycle; that beat SHALL be discarded.
REQ-033 In IDLE and ACC, out_* ports other than out_valid SHALL hold their previous values.

Reset
REQ-034 rst_n = 0 SHALL immediately force IDLE, in_ready = 1, out_valid = 0, and out_sum, out_q, out_cnt, out_ovf, acc, cnt, ovf all 0.
REQ-035 Reset asserted mid-frame or in OUT SHALL discard all partial and pending results.
REQ-036 After reset release, the first accepted beat SHALL start a new frame using bias.

Verification
REQ-037 Basic frame: bias = 0, shift = 0, terms 100, 200, -50 (-50 with in_last) -> one cycle later out_valid = 1, out_sum = 250, out_cnt = 3, out_q = 127 (saturated), out_ovf = 0.
REQ-038 Rounding: shift = 2, bias = 0, single term 10 with in_last -> out_q = 3; single term -10 -> out_q = -2.
REQ-039 Backpressure: out_ready = 0 for 5 cycles after a frame -> in_ready = 0 and outputs stable throughout; on the out_ready = 1 cycle the handshake completes, and the next frame is accepted from the cycle after.
REQ-040 Overflow: bias = 2147483647, terms 1 then 5 with in_last -> out_sum = 2147483647, out_ovf = 1, out_cnt = 2; a following clean frame -> out_ovf = 0.
REQ-041 Abort: clr asserted with the 2nd of 3 beats -> that beat is dropped and the state is IDLE; a new frame of terms 7, 8 (8 with in_last) -> out_sum = bias + 15, out_cnt = 2.
REQ-042 Reset in OUT: rst_n pulsed low while out_valid = 1 -> out_valid = 0 and all outputs 0 asynchronously, before the next clock edge.

Source files
------------

// File: rtl/mac_acc.sv
// ============================================================================
// Module   : mac_acc
// Brief    : Saturating multiply-accumulate frame accumulator with round/shift
//            requantization and a valid/ready result hold.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mac_acc #(
  parameter int IW = 18,
  parameter int AW = 32,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_last,
  input  logic [AW-1:0] bias,
  input  logic [4:0]    shift,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_sum,
  output logic [QW-1:0] out_q,
  output logic [15:0]   out_cnt,
  output logic          out_ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] out_sum_q, out_sum_d;
  logic [QW-1:0] out_q_q, out_q_d;
  logic [15:0]   out_cnt_q, out_cnt_d;
  logic          out_ovf_q, out_ovf_d;

  logic               accept_w;
  logic [AW-1:0]      base_w;
  logic [AW:0]        sum_w;
  logic               add_ovf_w;
  logic [AW-1:0]      add_sat_w;
  logic [15:0]        cnt_nxt_w;
  logic               ovf_nxt_w;
  logic [AW:0]        rnd_w;
  logic signed [AW:0] wide_w;
  logic signed [AW:0] shr_w;
  logic [QW-1:0]      q_sat_w;

  assign in_ready  = (state_q != S_OUT);
  assign out_valid = (state_q == S_OUT);
  assign accept_w  = in_valid && in_ready && !clr;

  // The first beat of a frame adds onto bias instead of the running sum.
  assign base_w    = (state_q == S_IDLE) ? bias : acc_q;
  assign sum_w     = {base_w[AW-1], base_w} + {{(AW+1-IW){in_data[IW-1]}}, in_data};
  assign add_ovf_w = sum_w[AW] ^ sum_w[AW-1];
  assign add_sat_w = !add_ovf_w ? sum_w[AW-1:0] :
                     (sum_w[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}});
  assign cnt_nxt_w = (state_q == S_IDLE) ? 16'd1 :
                     ((cnt_q == 16'hFFFF) ? 16'hFFFF : cnt_q + 16'd1);
  assign ovf_nxt_w = ((state_q == S_IDLE) ? 1'b0 : ovf_q) | add_ovf_w;

  // Requantize the value being written into the accumulator so the result is
  // ready on the same edge that captures the final sum.
  assign rnd_w  = (shift == 5'd0) ? '0 : ((AW+1)'(1) << (shift - 5'd1));
  assign wide_w = $signed({add_sat_w[AW-1], add_sat_w}) + $signed(rnd_w);
  assign shr_w  = wide_w >>> shift;

  always_comb begin
    q_sat_w = shr_w[QW-1:0];
    if (!((&shr_w[AW:QW-1]) || !(|shr_w[AW:QW-1]))) begin
      q_sat_w = shr_w[AW] ? {1'b1, {(QW-1){1'b0}}} : {1'b0, {(QW-1){1'b1}}};
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    out_sum_d = out_sum_q;
    out_q_d   = out_q_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;

    if (accept_w) begin
      acc_d = add_sat_w;
      cnt_d = cnt_nxt_w;
      ovf_d = ovf_nxt_w;
      if (in_last) begin
        state_d   = S_OUT;
        out_sum_d = add_sat_w;
        out_q_d   = q_sat_w;
        out_cnt_d = cnt_nxt_w;
        out_ovf_d = ovf_nxt_w;
      end else begin
        state_d = S_ACC;
      end
    end

    if ((state_q == S_OUT) && out_ready) begin
      state_d = S_IDLE;
    end

    if (clr) begin
      state_d = S_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      out_sum_q <= '0;
      out_q_q   <= '0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      out_sum_q <= out_sum_d;
      out_q_q   <= out_q_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  assign out_sum = out_sum_q;
  assign out_q   = out_q_q;
  assign out_cnt = out_cnt_q;
  assign out_ovf = out_ovf_q;

endmodule

`default_nettype wire
